// File: rtl/aes_inv_round_ctrl.sv
// Round sequencer for the AES inverse cipher: steps one block through LOAD,
// NR-1 inverse rounds and the final inverse round, stalling whenever rk_valid is low.
module aes_inv_round_ctrl #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] rk_idx,
  input  logic       rk_valid,
  output logic [1:0] op_sel,
  output logic       state_we,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
    $error("aes_inv_round_ctrl: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_IDX   = 4'(NR);
  localparam logic [3:0] RND_INIT = 4'(NR - 1);
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ROUND = 2'b01;
  localparam logic [1:0] OP_FINAL = 2'b10;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  state_t     state_reg, state_next;
  logic [3:0] rnd_reg, rnd_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      rnd_reg   <= RND_INIT;
    end else begin
      state_reg <= state_next;
      rnd_reg   <= rnd_next;
    end
  end

  // Handshake outputs are gated by reset so an in-flight or arriving block
  // never writes the datapath in the reset cycle.
  always_comb begin
    state_next = state_reg;
    rnd_next   = rnd_reg;
    rk_idx     = NR_IDX;
    op_sel     = OP_LOAD;
    in_ready   = 1'b0;
    state_we   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy     = 1'b0;
        in_ready = rk_valid && !reset;
        state_we = in_valid && rk_valid && !reset;
        if (in_valid && rk_valid) begin
          rnd_next   = RND_INIT;
          state_next = ROUND;
        end
      end
      ROUND: begin
        rk_idx   = rnd_reg;
        op_sel   = OP_ROUND;
        state_we = rk_valid && !reset;
        if (rk_valid) begin
          if (rnd_reg == 4'd1) begin
            state_next = FINAL;
          end else begin
            rnd_next = rnd_reg - 4'd1;
          end
        end
      end
      FINAL: begin
        rk_idx   = 4'd0;
        op_sel   = OP_FINAL;
        state_we = rk_valid && !reset;
        if (rk_valid) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: cycle table, hand-written corner sequences,
// an AES-128 datapath model for FIPS-197 C.1, and a randomized scoreboard run.
module tb_aes_inv_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, in_valid, rk_valid, out_ready;
  logic       ir0, we0, ov0, bz0, ir1, we1, ov1, bz1;
  logic [3:0] idx0, idx1;
  logic [1:0] op0, op1;

  aes_inv_round_ctrl u_dut10 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0), .rk_idx(idx0),
    .rk_valid(rk_valid), .op_sel(op0), .state_we(we0), .out_valid(ov0),
    .out_ready(out_ready), .busy(bz0)
  );

  aes_inv_round_ctrl #(.NR(14)) u_dut14 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .rk_idx(idx1),
    .rk_valid(rk_valid), .op_sel(op1), .state_we(we1), .out_valid(ov1),
    .out_ready(out_ready), .busy(bz1)
  );

  int   total = 0;
  int   bad = 0;
  logic sel14 = 1'b0;

  wire [3:0] s_idx = sel14 ? idx1 : idx0;
  wire [1:0] s_op  = sel14 ? op1 : op0;
  wire       s_we  = sel14 ? we1 : we0;
  wire       s_ov  = sel14 ? ov1 : ov0;
  wire       s_ir  = sel14 ? ir1 : ir0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- AES-128 datapath model ----------------
  logic [7:0]   sbox [256];
  logic [7:0]   isbox[256];
  logic [127:0] rks[15];
  logic [127:0] in_block, dp_state;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_rnd(input logic [127:0] s, input logic [127:0] key, input bit mix);
    logic [7:0]   a[16], b[16], c0, c1, c2, c3;
    logic [127:0] r;
    for (int k = 0; k < 16; k++) a[k] = s[127-8*k -: 8];
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        b[4*c+rw] = isbox[a[4*((c+4-rw)%4)+rw]];
    for (int k = 0; k < 16; k++) b[k] = b[k] ^ key[127-8*k -: 8];
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
        b[4*c]   = gmul(c0, 8'h0e) ^ gmul(c1, 8'h0b) ^ gmul(c2, 8'h0d) ^ gmul(c3, 8'h09);
        b[4*c+1] = gmul(c0, 8'h09) ^ gmul(c1, 8'h0e) ^ gmul(c2, 8'h0b) ^ gmul(c3, 8'h0d);
        b[4*c+2] = gmul(c0, 8'h0d) ^ gmul(c1, 8'h09) ^ gmul(c2, 8'h0e) ^ gmul(c3, 8'h0b);
        b[4*c+3] = gmul(c0, 8'h0b) ^ gmul(c1, 8'h0d) ^ gmul(c2, 8'h09) ^ gmul(c3, 8'h0e);
      end
    end
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = b[k];
    return r;
  endfunction

  task automatic build_tables(input logic [127:0] key);
    logic [7:0]  inv, x;
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 256; i++) begin
      inv = 8'h01;
      for (int j = 0; j < 254; j++) inv = gmul(inv, 8'(i));
      if (i == 0) inv = 8'h00;
      x = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[i] = x;
      isbox[x] = 8'(i);
    end
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 15; r++) rks[r] = '0;
    for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  always @(posedge clk) begin
    if (we0 === 1'b1) begin
      case (op0)
        2'b00:   dp_state <= in_block ^ rks[idx0];
        2'b01:   dp_state <= inv_rnd(dp_state, rks[idx0], 1'b1);
        2'b10:   dp_state <= inv_rnd(dp_state, rks[idx0], 1'b0);
        default: dp_state <= dp_state;
      endcase
    end
  end

  // ---------------- Scoreboard: remaining key steps per block ----------------
  int left[2];
  bit done[2];

  function automatic int nr_of(input int i);
    return (i == 0) ? 10 : 14;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        left[i] <= 0;
        done[i] <= 1'b0;
      end else if (left[i] == 0 && !done[i]) begin
        if (in_valid && rk_valid) left[i] <= nr_of(i);
      end else if (left[i] > 0) begin
        if (rk_valid) begin
          left[i] <= left[i] - 1;
          if (left[i] == 1) done[i] <= 1'b1;
        end
      end else if (out_ready) begin
        done[i] <= 1'b0;
      end
    end
  end

  task automatic check_model(input int i, input logic [3:0] idx, input logic [1:0] op,
                             input logic we, input logic ov, input logic ir, input logic bz);
    int nr;
    nr = nr_of(i);
    if (left[i] == 0 && !done[i]) begin
      chk("rnd_idle_idx", idx, nr);
      chk("rnd_idle_op", op, 0);
      chk("rnd_idle_we", we, int'(in_valid && rk_valid && !reset));
      chk("rnd_idle_ready", ir, int'(rk_valid && !reset));
      chk("rnd_idle_ov", ov, 0);
      chk("rnd_idle_busy", bz, 0);
    end else if (left[i] > 0) begin
      chk("rnd_work_idx", idx, left[i] - 1);
      chk("rnd_work_op", op, (left[i] == 1) ? 2 : 1);
      chk("rnd_work_we", we, int'(rk_valid && !reset));
      chk("rnd_work_ready", ir, 0);
      chk("rnd_work_ov", ov, 0);
      chk("rnd_work_busy", bz, 1);
    end else begin
      chk("rnd_done_idx", idx, nr);
      chk("rnd_done_we", we, 0);
      chk("rnd_done_ready", ir, 0);
      chk("rnd_done_ov", ov, 1);
      chk("rnd_done_busy", bz, 1);
    end
  endtask

  // ---------------- Block-level helpers ----------------
  task automatic run_block(input int stall_key, input int stall_n, output int lat, output int writes);
    int exp_key, stalled, nr;
    bit seen;
    nr = sel14 ? 14 : 10;
    exp_key = nr - 1; stalled = 0; seen = 1'b0; writes = 0;
    in_valid = 1'b1; rk_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk("accept_ready", s_ir, 1);
    chk("load_we", s_we, 1);
    chk("load_idx", s_idx, nr);
    chk("load_op", s_op, 0);
    writes += int'(s_we);
    cyc();
    in_valid = 1'b0;
    lat = 1;
    for (int c = 0; c < 60; c++) begin
      if (int'(s_idx) == stall_key && stalled < stall_n) begin
        rk_valid = 1'b0;
        stalled++;
      end else begin
        rk_valid = 1'b1;
      end
      @(negedge clk);
      if (s_ov) begin
        seen = 1'b1;
        break;
      end
      if (!rk_valid) begin
        chk("stall_idx", s_idx, stall_key);
        chk("stall_we", s_we, 0);
      end else begin
        chk("round_we", s_we, 1);
        chk("round_idx", s_idx, exp_key);
        chk("round_op", s_op, (exp_key == 0) ? 2 : 1);
        exp_key--;
      end
      writes += int'(s_we);
      cyc();
      lat++;
    end
    if (!seen) chk("out_valid_timeout", 0, 1);
    $display("block nr=%0d latency=%0d writes=%0d", nr, lat, writes);
  endtask

  task automatic release_done();
    cyc();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  typedef struct {
    int rst, iv, rv, ordy;
    int idx, op, we, ov, ir, bz;
  } vec_t;

  vec_t tbl[16];
  int   lat, writes;
  bit   hit;

  initial begin
    reset = 1'b1; in_valid = 1'b0; rk_valid = 1'b1; out_ready = 1'b0;
    in_block = 128'h0; dp_state = 128'h0;
    build_tables(128'h000102030405060708090a0b0c0d0e0f);

    // op = -1 marks a don't-care operation select (DONE state)
    tbl[0]  = '{1, 1, 1, 0, 10, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 0, 10, 0, 1, 0, 1, 0};
    for (int k = 2; k <= 10; k++) tbl[k] = '{0, 1, 1, 0, 11 - k, 1, 1, 0, 0, 1};
    tbl[11] = '{0, 0, 1, 0, 0, 2, 1, 0, 0, 1};
    tbl[12] = '{0, 1, 1, 0, 10, -1, 0, 1, 0, 1};
    tbl[13] = '{0, 0, 1, 1, 10, -1, 0, 1, 0, 1};
    tbl[14] = '{0, 0, 0, 0, 10, 0, 0, 0, 0, 0};
    tbl[15] = '{0, 0, 1, 0, 10, 0, 0, 0, 1, 0};

    cyc();
    cyc();

    for (int v = 0; v < 16; v++) begin
      reset = tbl[v].rst[0]; in_valid = tbl[v].iv[0];
      rk_valid = tbl[v].rv[0]; out_ready = tbl[v].ordy[0];
      @(negedge clk);
      chk($sformatf("vec%0d_idx", v), idx0, tbl[v].idx);
      if (tbl[v].op >= 0) chk($sformatf("vec%0d_op", v), op0, tbl[v].op);
      chk($sformatf("vec%0d_we", v), we0, tbl[v].we);
      chk($sformatf("vec%0d_ov", v), ov0, tbl[v].ov);
      chk($sformatf("vec%0d_ready", v), ir0, tbl[v].ir);
      chk($sformatf("vec%0d_busy", v), bz0, tbl[v].bz);
      $display("vec %0d idx=%0d op=%0d we=%0d ov=%0d ready=%0d busy=%0d", v, idx0, op0, we0, ov0, ir0, bz0);
      cyc();
    end

    // Stall at round key 5 for 3 cycles, end-to-end FIPS-197 C.1 decryption
    in_block = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    run_block(5, 3, lat, writes);
    chk("stall_latency", lat, 14);
    chk("stall_writes", writes, 11);
    total++;
    if (dp_state !== 128'h00112233445566778899aabbccddeeff) begin
      bad++;
      $display("FAIL aes_plaintext: got %h, expected 00112233445566778899aabbccddeeff", dp_state);
    end
    release_done();

    // out_ready withheld in DONE while in_valid stays high
    run_block(-1, 0, lat, writes);
    chk("plain_latency", lat, 11);
    for (int j = 0; j < 3; j++) begin
      cyc();
      in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      chk("hold_ov", ov0, 1);
      chk("hold_ready", ir0, 0);
      chk("hold_we", we0, 0);
    end
    cyc();
    out_ready = 1'b1;
    @(negedge clk);
    chk("handshake_ov", ov0, 1);
    chk("handshake_ready", ir0, 0);
    chk("handshake_we", we0, 0);
    cyc();
    out_ready = 1'b0;
    @(negedge clk);
    chk("reaccept_ov", ov0, 0);
    chk("reaccept_ready", ir0, 1);
    chk("reaccept_we", we0, 1);
    chk("reaccept_busy", bz0, 0);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("reaccept_round_idx", idx0, 9);
    chk("reaccept_round_busy", bz0, 1);

    // Reset strikes while rk_idx is 4
    hit = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (idx0 == 4'd4) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) chk("reach_rnd4_timeout", 0, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_cycle_we", we0, 0);
    chk("reset_cycle_ready", ir0, 0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", bz0, 0);
    chk("post_reset_ov", ov0, 0);
    chk("post_reset_idx", idx0, 10);
    chk("post_reset_op", op0, 0);
    chk("post_reset_ready", ir0, 1);
    cyc();
    run_block(-1, 0, lat, writes);
    chk("after_reset_latency", lat, 11);
    chk("after_reset_writes", writes, 11);
    release_done();

    // NR=14 instance from a clean reset
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    sel14 = 1'b1;
    run_block(-1, 0, lat, writes);
    chk("nr14_latency", lat, 15);
    chk("nr14_writes", writes, 15);
    release_done();
    sel14 = 1'b0;

    // Randomized run against the step-count scoreboard, both instances
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 59) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      rk_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_block  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check_model(0, idx0, op0, we0, ov0, ir0, bz0);
      check_model(1, idx1, op1, we1, ov1, ir1, bz1);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
